vga_sync_to_count: RTL and testbench
====================================

Name: vga_sync_to_count

Overview:
- Receive-side companion to the porch/sync generator. Takes the porch-adjusted Hsync/Vsync stream and rebuilds column/row counters from it.
- Sync levels: high = active or porch; low = sync pulse. Vsync rising edge = frame start.
- Checks each frame length against the expected raster and reports lock, so downstream pixel logic can trust the counts.
- Flywheels across brief Vsync loss.

Parameters:
- TOTAL_COLS, 800, clocks per line; column counter wraps after TOTAL_COLS-1.
- TOTAL_ROWS, 525, lines per frame; row counter wraps after TOTAL_ROWS-1.
- MISS_LIMIT, 2, consecutive frames without Vsync edge tolerated in LOCKED before dropping to UNLOCKED (range 1-7).

Ports:
- i_Clk  input  1  pixel clock; all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Hsync  input  1  incoming horizontal sync (low = pulse).
- i_Vsync  input  1  incoming vertical sync (low = pulse).
- o_Hsync  output  1  i_Hsync delayed 1 clock, aligned to counts.
- o_Vsync  output  1  i_Vsync delayed 1 clock, aligned to counts.
- o_Col_Count  output  10  recovered column, 0..TOTAL_COLS-1.
- o_Row_Count  output  10  recovered row, 0..TOTAL_ROWS-1.
- o_Frame_Start  output  1  one-clock pulse when counts load (0,0).
- o_Locked  output  1  high while state is LOCKED.
- o_Sync_Err  output  1  one-clock pulse on frame-length mismatch or missed Vsync.

Behaviour:
- Reset values: o_Hsync=1, o_Vsync=1, counts=0, o_Frame_Start=0, o_Locked=0, o_Sync_Err=0. Internal state: UNLOCKED, miss count 0, previous-Vsync register=1.
- Edge detect:
  - S = i_Vsync & ~prev. prev <= i_Vsync every clock.
  - Because prev resets to 1, a Vsync already high at reset release is not a false edge.
- Alignment: on the edge where S is seen, counts load 0,0 and o_Vsync becomes 1 in the same cycle. Latency from i_Vsync rise to (o_Col_Count=0, o_Row_Count=0) is 1 clock.
- Counting (ACQUIRE/LOCKED, no S):
  - col+1. At col=TOTAL_COLS-1, col->0 and row+1.
  - At (TOTAL_COLS-1, TOTAL_ROWS-1), both ->0 (natural wrap).
- Frame check: "end" means counts equal (TOTAL_COLS-1, TOTAL_ROWS-1) on the cycle S is seen.
- UNLOCKED:
  - Counts held 0.
  - On S: load 0,0 -> ACQUIRE; o_Frame_Start=1.
- ACQUIRE:
  - S at end: -> LOCKED; miss=0; load 0,0; o_Frame_Start=1.
  - S not at end: stay ACQUIRE; reload 0,0; o_Sync_Err=1; o_Frame_Start=1.
  - Natural wrap with no S: -> UNLOCKED; o_Sync_Err=1; counts 0.
- LOCKED:
  - S at end: miss=0; load 0,0; o_Frame_Start=1.
  - S not at end: -> ACQUIRE; o_Sync_Err=1; load 0,0; o_Frame_Start=1.
  - Natural wrap with no S: miss+1; o_Sync_Err=1.
    - If miss+1 < MISS_LIMIT: stay LOCKED, flywheel (counts wrap to 0,0; o_Frame_Start=1).
    - Else: -> UNLOCKED; counts 0; no o_Frame_Start.
- o_Locked is registered and reflects the current state (high the cycle after entering LOCKED).
- S takes priority over natural wrap on the same cycle.
- Hsync is passed through for alignment only and is not checked.
- Counters never exceed their wrap value; 10-bit width is fixed.
- i_Reset mid-frame: all outputs return to reset values on the next edge, regardless of state.

Test Plan:
- Reset, then clean 800x525 raster (Vsync low 2 lines, rising at frame start):
  - First rise -> o_Frame_Start, counts 0,0 one clock later.
  - Second rise -> o_Locked=1 one clock after, o_Sync_Err never pulses.
- Locked; one Vsync rise arrives 5 lines early (row=519, col=799):
  - o_Sync_Err pulse, o_Locked drops, counts reload 0,0.
  - Next correct frame -> relocked.
- Locked; Vsync held high for 3 frames with MISS_LIMIT=2:
  - Frame 1 wrap -> err pulse, still locked, counts wrap to 0,0.
  - Frame 2 wrap -> err pulse, o_Locked=0, counts stay 0.
- i_Vsync=1 throughout reset release:
  - No o_Frame_Start until Vsync goes low then high.
- Locked; i_Reset asserted at row=200, col=300 for 1 clock:
  - Next cycle counts 0, o_Locked=0, o_Hsync/o_Vsync=1.
  - Relock takes two further frame starts.
- Locked; check wrap boundaries:
  - col 799->0 with row+1.
  - (799,524)->(0,0) coincident with Vsync rise: single o_Frame_Start, no err.
  - o_Hsync/o_Vsync equal i_Hsync/i_Vsync delayed exactly 1 clock.

Source files
------------

// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count
// Rebuilds column/row counters from a porch-adjusted Hsync/Vsync stream.
// A rising edge on Vsync marks the start of a frame. Each frame's length is
// checked against the expected raster. Lock is reported once two consecutive
// frames agree. While locked, the counters flywheel across a limited number
// of missing Vsync edges.
//
// Ports:
//   i_Clk          pixel clock, all logic on the rising edge
//   i_Reset        synchronous active-high reset
//   i_Hsync        incoming horizontal sync (low = pulse)
//   i_Vsync        incoming vertical sync (low = pulse)
//   o_Hsync        i_Hsync delayed one clock, aligned to the counts
//   o_Vsync        i_Vsync delayed one clock, aligned to the counts
//   o_Col_Count    recovered column, 0..TOTAL_COLS-1
//   o_Row_Count    recovered row, 0..TOTAL_ROWS-1
//   o_Frame_Start  one-clock pulse in the cycle the counts read (0,0)
//   o_Locked       high while the recovery is LOCKED
//   o_Sync_Err     one-clock pulse on frame-length mismatch or missed Vsync
module vga_sync_to_count #(
    parameter int TOTAL_COLS = 800,
    parameter int TOTAL_ROWS = 525,
    parameter int MISS_LIMIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Hsync,
    input  logic       i_Vsync,
    output logic       o_Hsync,
    output logic       o_Vsync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Sync_Err
);

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       prev_vsync;
    logic [2:0] miss, miss_nxt;
    logic [3:0] miss_inc;
    logic [9:0] col, row, col_nxt, row_nxt, col_adv, row_adv;
    logic       vsync_rise, line_end, frame_end;
    logic       frame_start_nxt, sync_err_nxt;

    // prev_vsync resets high, so a Vsync already high at reset release
    // is not taken as a frame start.
    assign vsync_rise = i_Vsync & ~prev_vsync;
    assign line_end   = (col == COL_LAST);
    assign frame_end  = line_end && (row == ROW_LAST);
    assign miss_inc   = {1'b0, miss} + 4'd1;

    // Free-running raster advance, used whenever no edge or wrap rule
    // overrides it.
    always_comb begin
        col_adv = line_end ? 10'd0 : col + 10'd1;
        row_adv = row;
        if (frame_end)
            row_adv = 10'd0;
        else if (line_end)
            row_adv = row + 10'd1;
    end

    always_comb begin
        state_nxt       = state;
        miss_nxt        = miss;
        col_nxt         = col_adv;
        row_nxt         = row_adv;
        frame_start_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        case (state)
            UNLOCKED: begin
                col_nxt = 10'd0;
                row_nxt = 10'd0;
                if (vsync_rise) begin
                    state_nxt       = ACQUIRE;
                    frame_start_nxt = 1'b1;
                end
            end
            ACQUIRE, LOCKED: begin
                // A Vsync edge wins over the natural wrap in the same cycle.
                if (vsync_rise) begin
                    col_nxt         = 10'd0;
                    row_nxt         = 10'd0;
                    frame_start_nxt = 1'b1;
                    if (frame_end) begin
                        state_nxt = LOCKED;
                        miss_nxt  = 3'd0;
                    end else begin
                        state_nxt    = ACQUIRE;
                        sync_err_nxt = 1'b1;
                    end
                end else if (frame_end) begin
                    // The frame ran out with no Vsync edge. Counts already
                    // wrap to (0,0) through the advance logic.
                    sync_err_nxt = 1'b1;
                    if (state == LOCKED && miss_inc < MISS_MAX) begin
                        miss_nxt        = miss_inc[2:0];
                        frame_start_nxt = 1'b1;
                    end else begin
                        state_nxt = UNLOCKED;
                        miss_nxt  = 3'd0;
                    end
                end
            end
            default: begin
                state_nxt = UNLOCKED;
                col_nxt   = 10'd0;
                row_nxt   = 10'd0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= UNLOCKED;
            miss          <= 3'd0;
            prev_vsync    <= 1'b1;
            col           <= 10'd0;
            row           <= 10'd0;
            o_Hsync       <= 1'b1;
            o_Vsync       <= 1'b1;
            o_Frame_Start <= 1'b0;
            o_Locked      <= 1'b0;
            o_Sync_Err    <= 1'b0;
        end else begin
            state         <= state_nxt;
            miss          <= miss_nxt;
            prev_vsync    <= i_Vsync;
            col           <= col_nxt;
            row           <= row_nxt;
            o_Hsync       <= i_Hsync;
            o_Vsync       <= i_Vsync;
            o_Frame_Start <= frame_start_nxt;
            o_Locked      <= (state_nxt == LOCKED);
            o_Sync_Err    <= sync_err_nxt;
        end
    end

    assign o_Col_Count = col;
    assign o_Row_Count = row;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Testbench for vga_sync_to_count. It uses a reduced raster (16x10) so that
// many whole frames fit in a short run. The reference model tracks the
// recovered position as one linear index into the frame.
module tb_vga_sync_to_count;

    localparam int C     = 16;
    localparam int R     = 10;
    localparam int FRAME = C * R;
    localparam int LIMIT = 2;
    localparam int IDLE  = 0;
    localparam int TRACK = 1;
    localparam int HELD  = 2;

    logic       clk;
    logic       i_Reset, i_Hsync, i_Vsync;
    logic       o_Hsync, o_Vsync, o_Frame_Start, o_Locked, o_Sync_Err;
    logic [9:0] o_Col_Count, o_Row_Count;

    int checks = 0;
    int fails  = 0;
    int spos   = 0;      // source raster position
    int m_pos, m_mode, m_miss;
    bit m_prev;
    logic [24:0] exp_v;

    vga_sync_to_count #(.TOTAL_COLS(C), .TOTAL_ROWS(R), .MISS_LIMIT(LIMIT)) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Hsync(i_Hsync), .i_Vsync(i_Vsync),
        .o_Hsync(o_Hsync), .o_Vsync(o_Vsync),
        .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
        .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked), .o_Sync_Err(o_Sync_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] got_vec();
        return {o_Hsync, o_Vsync, o_Col_Count, o_Row_Count, o_Frame_Start, o_Locked, o_Sync_Err};
    endfunction

    // Reference behaviour: expected outputs after one clock with these inputs.
    task automatic model_step(input bit rst, input bit h, input bit v);
        bit rise, last, fs, err;
        fs  = 1'b0;
        err = 1'b0;
        if (rst) begin
            m_pos = 0; m_mode = IDLE; m_miss = 0; m_prev = 1'b1;
            exp_v = {2'b11, 20'd0, 3'b000};
        end else begin
            rise   = v && !m_prev;
            m_prev = v;
            last   = (m_pos == FRAME - 1);
            if (m_mode == IDLE) begin
                m_pos = 0;
                if (rise) begin m_mode = TRACK; fs = 1'b1; end
            end else if (rise) begin
                fs = 1'b1; m_pos = 0;
                if (last) begin m_mode = HELD; m_miss = 0; end
                else begin m_mode = TRACK; err = 1'b1; end
            end else if (last) begin
                err = 1'b1; m_pos = 0;
                if (m_mode == HELD && m_miss + 1 < LIMIT) begin m_miss++; fs = 1'b1; end
                else begin m_mode = IDLE; m_miss = 0; end
            end else begin
                m_pos++;
            end
            exp_v = {h, v, 10'(m_pos % C), 10'(m_pos / C), fs, (m_mode == HELD), err};
        end
    endtask

    // Source raster: Vsync low for the last two lines, so it rises at
    // position 0. Hsync is a short pulse at the start of each line, with
    // random glitches added because it only needs to pass through.
    task automatic src_next(output bit h, output bit v);
        v = (spos < FRAME - 2 * C);
        h = ((spos % C) >= 2) ^ ($urandom_range(0, 7) == 0);
        spos = (spos + 1) % FRAME;
    endtask

    task automatic step(input bit rst, input bit h, input bit v);
        i_Reset = rst; i_Hsync = h; i_Vsync = v;
        @(posedge clk);
        model_step(rst, h, v);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)), (k == 4) ? 1'b1 : 1'($urandom_range(0, 1)));
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL reset_values: got %h expected %h", got_vec(), exp_v);
            end
        end
    endtask

    task automatic test_no_false_edge();
        int fs_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL vsync_high_release: got %h expected %h", got_vec(), exp_v);
            end
            if (o_Frame_Start) fs_cnt++;
        end
        checks++;
        if (fs_cnt !== 0) begin
            fails++;
            $display("FAIL no_false_frame_start: pulses %0d expected 0", fs_cnt);
        end
    endtask

    task automatic test_acquire_lock();
        bit h, v;
        int errs = 0, fs_cnt = 0;
        spos = FRAME - 3;
        for (int k = 0; k < 3 * FRAME; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL acquire_lock: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
            if (o_Sync_Err) errs++;
            if (o_Frame_Start) fs_cnt++;
        end
        checks++;
        if (o_Locked !== 1'b1 || errs !== 0 || fs_cnt !== 3) begin
            fails++;
            $display("FAIL lock_clean: locked=%b errs=%0d fs=%0d expected 1/0/3", o_Locked, errs, fs_cnt);
        end
    endtask

    task automatic test_early_vsync();
        bit h, v;
        int errs = 0;
        int pre = 3 + $urandom_range(C, FRAME - 3 * C);
        for (int k = 0; k < pre + 3 * FRAME; k++) begin
            if (k == pre) spos = FRAME - 2 * C;   // cut the frame short
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL early_vsync: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
            if (k >= pre && o_Sync_Err) errs++;
        end
        checks++;
        if (o_Locked !== 1'b1 || errs !== 1) begin
            fails++;
            $display("FAIL early_relock: locked=%b errs=%0d expected 1/1", o_Locked, errs);
        end
    endtask

    task automatic test_flywheel();
        bit h, v;
        int errs = 0;
        for (int k = 0; k < FRAME && spos != 1; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL flywheel_align: got %h expected %h", got_vec(), exp_v);
            end
        end
        for (int k = 0; k < 3 * FRAME; k++) begin
            src_next(h, v);
            step(1'b0, h, 1'b1);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL flywheel_hold: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
            if (o_Sync_Err) errs++;
        end
        checks++;
        if (o_Locked !== 1'b0 || errs !== 2) begin
            fails++;
            $display("FAIL flywheel_drop: locked=%b errs=%0d expected 0/2", o_Locked, errs);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL flywheel_relock: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
        end
        checks++;
        if (o_Locked !== 1'b1) begin
            fails++;
            $display("FAIL flywheel_relocked: locked=%b expected 1", o_Locked);
        end
    endtask

    task automatic test_mid_reset();
        bit h, v;
        int pre = $urandom_range(2 * C, FRAME - 3 * C);
        for (int k = 0; k < pre; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL mid_reset_pre: got %h expected %h", got_vec(), exp_v);
            end
        end
        src_next(h, v);
        step(1'b1, h, v);
        checks++;
        if (got_vec() !== {2'b11, 20'd0, 3'b000}) begin
            fails++;
            $display("FAIL mid_reset_values: got %h expected %h", got_vec(), {2'b11, 20'd0, 3'b000});
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL mid_reset_relock: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
        end
        checks++;
        if (o_Locked !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_locked: locked=%b expected 1", o_Locked);
        end
    endtask

    task automatic test_wrap_boundaries();
        bit h, v;
        int errs = 0, fs_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            src_next(h, v);
            step(1'b0, h, v);
            checks++;
            if (got_vec() !== exp_v) begin
                fails++;
                $display("FAIL wrap_boundary: got %h expected %h k=%0d", got_vec(), exp_v, k);
            end
            if (o_Sync_Err) errs++;
            if (o_Frame_Start) fs_cnt++;
        end
        checks++;
        if (errs !== 0 || fs_cnt !== 1) begin
            fails++;
            $display("FAIL wrap_single_start: errs=%0d fs=%0d expected 0/1", errs, fs_cnt);
        end
    endtask

    task automatic test_random_jumps();
        bit h, v;
        for (int j = 0; j < 6; j++) begin
            int n = $urandom_range(20, 2 * FRAME);
            if ($urandom_range(0, 1) == 1) spos = $urandom_range(0, FRAME - 1);
            for (int k = 0; k < n; k++) begin
                src_next(h, v);
                step(1'b0, h, v);
                checks++;
                if (got_vec() !== exp_v) begin
                    fails++;
                    $display("FAIL random_jumps: got %h expected %h j=%0d k=%0d", got_vec(), exp_v, j, k);
                end
            end
        end
    endtask

    initial begin
        i_Reset = 1'b1; i_Hsync = 1'b1; i_Vsync = 1'b1;
        test_reset();
        test_no_false_edge();
        test_acquire_lock();
        test_early_vsync();
        test_flywheel();
        test_mid_reset();
        test_wrap_boundaries();
        test_random_jumps();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
